// File: rtl/wt_hybche_rd_arb.sv
// Read-side front end for the hybrid cache: round-robin arbitration of core load ports,
// single outstanding lookup, miss/non-cacheable forwarding to the miss unit.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | no transaction; grants the next requester unless flushing
// LOOKUP     | lookup request to cache memory, held until accepted
// COMPARE    | hit/miss result from memory; hit returns data here
// MISS_REQ   | miss request to miss unit, held until acknowledged
// MISS_WAIT  | waiting for the refill word, returned to the port
module wt_hybche_rd_arb #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned PLEN       = 56,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned IDX_WIDTH  = 12,
    parameter int unsigned TAG_WIDTH  = 44
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cache_en_i,
    input  logic                        flush_i,
    output logic                        idle_o,
    input  logic [NUM_PORTS-1:0]        port_req_i,
    input  logic [NUM_PORTS*PLEN-1:0]   port_addr_i,
    input  logic [NUM_PORTS-1:0]        port_kill_i,
    output logic [NUM_PORTS-1:0]        port_gnt_o,
    output logic [NUM_PORTS-1:0]        port_rvalid_o,
    output logic [DATA_WIDTH-1:0]       port_rdata_o,
    output logic                        lkp_req_o,
    output logic [IDX_WIDTH-1:0]        lkp_idx_o,
    output logic [TAG_WIDTH-1:0]        lkp_tag_o,
    input  logic                        lkp_gnt_i,
    input  logic                        lkp_hit_i,
    input  logic [DATA_WIDTH-1:0]       lkp_data_i,
    output logic                        miss_req_o,
    output logic [PLEN-1:0]             miss_addr_o,
    output logic                        miss_nc_o,
    input  logic                        miss_ack_i,
    input  logic                        miss_rvalid_i,
    input  logic [DATA_WIDTH-1:0]       miss_rdata_i
);

    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_COMPARE,
        ST_MISS_REQ,
        ST_MISS_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           rr_q, rr_d;
    logic [PW-1:0]           id_q, id_d;
    logic [PLEN-1:0]         addr_q, addr_d;
    logic                    nc_q, nc_d;
    logic                    kill_q;

    logic                    gnt_any;
    logic [PW-1:0]           gnt_id;
    logic [PLEN-1:0]         gnt_addr;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic                    kill_active;
    logic                    resp_fire;

    // First requester at or after the round-robin pointer; only IDLE may grant.
    always_comb begin
        int p;
        p       = 0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        if (state_q == ST_IDLE && !flush_i) begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                p = (int'(rr_q) + i) % int'(NUM_PORTS);
                if (!gnt_any && port_req_i[p]) begin
                    gnt_any = 1'b1;
                    gnt_id  = PW'(p);
                end
            end
        end
    end

    assign gnt_addr = port_addr_i[int'(gnt_id)*int'(PLEN) +: PLEN];

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        addr_d     = addr_q;
        nc_d       = nc_q;
        lkp_req_o  = 1'b0;
        miss_req_o = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    id_d   = gnt_id;
                    addr_d = gnt_addr;
                    rr_d   = (gnt_id == PW'(NUM_PORTS - 1)) ? '0 : gnt_id + 1'b1;
                    if (cache_en_i) begin
                        nc_d    = 1'b0;
                        state_d = ST_LOOKUP;
                    end else begin
                        nc_d    = 1'b1;
                        state_d = ST_MISS_REQ;
                    end
                end
            end
            ST_LOOKUP: begin
                lkp_req_o = 1'b1;
                if (lkp_gnt_i) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (lkp_hit_i) begin
                    resp_valid = 1'b1;
                    resp_data  = lkp_data_i;
                    state_d    = ST_IDLE;
                end else begin
                    nc_d    = 1'b0;
                    state_d = ST_MISS_REQ;
                end
            end
            ST_MISS_REQ: begin
                miss_req_o = 1'b1;
                if (miss_ack_i) begin
                    state_d = ST_MISS_WAIT;
                end
            end
            ST_MISS_WAIT: begin
                if (miss_rvalid_i) begin
                    resp_valid = 1'b1;
                    resp_data  = miss_rdata_i;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A kill arriving in the completing cycle still suppresses the response.
    assign kill_active = kill_q | port_kill_i[id_q];
    assign resp_fire   = resp_valid & ~kill_active;

    always_comb begin
        port_gnt_o = '0;
        if (gnt_any) begin
            port_gnt_o[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        port_rvalid_o = '0;
        if (resp_fire) begin
            port_rvalid_o[id_q] = 1'b1;
        end
    end

    assign port_rdata_o = resp_fire  ? resp_data : '0;
    assign lkp_idx_o    = lkp_req_o  ? addr_q[IDX_WIDTH-1:0] : '0;
    assign lkp_tag_o    = lkp_req_o  ? TAG_WIDTH'(addr_q[PLEN-1:IDX_WIDTH]) : '0;
    assign miss_addr_o  = miss_req_o ? addr_q : '0;
    assign miss_nc_o    = miss_req_o & nc_q;
    assign idle_o       = (state_q == ST_IDLE) && !gnt_any;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            nc_q    <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            nc_q    <= nc_d;
            if (state_q == ST_IDLE) begin
                kill_q <= 1'b0;
            end else if (port_kill_i[id_q]) begin
                kill_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wt_hybche_rd_arb.sv
// Directed bench for wt_hybche_rd_arb: hit/miss/non-cacheable paths, kill, flush, reset.
module tb_wt_hybche_rd_arb;

    localparam int NP = 2;
    localparam int PL = 56;
    localparam int DW = 64;
    localparam int IW = 12;
    localparam int TW = 44;

    localparam logic [PL-1:0] ADDR0 = 56'h00_0000_8000_1040;
    localparam logic [PL-1:0] ADDR1 = 56'h12_3456_789A_BCDE;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             cache_en_i;
    logic             flush_i;
    logic             idle_o;
    logic [NP-1:0]    port_req_i;
    logic [NP*PL-1:0] port_addr_i;
    logic [NP-1:0]    port_kill_i;
    logic [NP-1:0]    port_gnt_o;
    logic [NP-1:0]    port_rvalid_o;
    logic [DW-1:0]    port_rdata_o;
    logic             lkp_req_o;
    logic [IW-1:0]    lkp_idx_o;
    logic [TW-1:0]    lkp_tag_o;
    logic             lkp_gnt_i;
    logic             lkp_hit_i;
    logic [DW-1:0]    lkp_data_i;
    logic             miss_req_o;
    logic [PL-1:0]    miss_addr_o;
    logic             miss_nc_o;
    logic             miss_ack_i;
    logic             miss_rvalid_i;
    logic [DW-1:0]    miss_rdata_i;

    int n_checks = 0;
    int n_pass   = 0;

    wt_hybche_rd_arb dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cache_en_i    (cache_en_i),
        .flush_i       (flush_i),
        .idle_o        (idle_o),
        .port_req_i    (port_req_i),
        .port_addr_i   (port_addr_i),
        .port_kill_i   (port_kill_i),
        .port_gnt_o    (port_gnt_o),
        .port_rvalid_o (port_rvalid_o),
        .port_rdata_o  (port_rdata_o),
        .lkp_req_o     (lkp_req_o),
        .lkp_idx_o     (lkp_idx_o),
        .lkp_tag_o     (lkp_tag_o),
        .lkp_gnt_i     (lkp_gnt_i),
        .lkp_hit_i     (lkp_hit_i),
        .lkp_data_i    (lkp_data_i),
        .miss_req_o    (miss_req_o),
        .miss_addr_o   (miss_addr_o),
        .miss_nc_o     (miss_nc_o),
        .miss_ack_i    (miss_ack_i),
        .miss_rvalid_i (miss_rvalid_i),
        .miss_rdata_i  (miss_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Move 1 time unit past the active edge; inputs are driven here.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Inputs have settled; compare combinational outputs of the current cycle.
    task automatic settle();
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"},    64'(port_gnt_o),    64'h0);
        chk({tag, "_rvalid"}, 64'(port_rvalid_o), 64'h0);
        chk({tag, "_lkp"},    64'(lkp_req_o),     64'h0);
        chk({tag, "_miss"},   64'(miss_req_o),    64'h0);
        chk({tag, "_rdata"},  64'(port_rdata_o),  64'h0);
        chk({tag, "_maddr"},  64'(miss_addr_o),   64'h0);
        chk({tag, "_nc"},     64'(miss_nc_o),     64'h0);
        chk({tag, "_idle"},   64'(idle_o),        64'h1);
    endtask

    initial begin
        rst_i         = 1'b1;
        cache_en_i    = 1'b1;
        flush_i       = 1'b0;
        port_req_i    = '0;
        port_addr_i   = {ADDR1, ADDR0};
        port_kill_i   = '0;
        lkp_gnt_i     = 1'b0;
        lkp_hit_i     = 1'b0;
        lkp_data_i    = '0;
        miss_ack_i    = 1'b0;
        miss_rvalid_i = 1'b0;
        miss_rdata_i  = '0;

        next_cycle();
        next_cycle();
        settle();
        chk_quiet("reset");
        rst_i = 1'b0;

        // Both ports request continuously, every lookup hits.
        next_cycle();
        port_req_i = 2'b11; lkp_gnt_i = 1'b1; lkp_hit_i = 1'b1;
        settle();
        chk("rr_gnt0", 64'(port_gnt_o), 64'h1);
        chk("rr_gnt0_idle", 64'(idle_o), 64'h0);
        next_cycle(); settle();
        chk("rr_lkp0", 64'(lkp_req_o), 64'h1);
        chk("rr_idx0", 64'(lkp_idx_o), 64'h040);
        chk("rr_tag0", 64'(lkp_tag_o), 64'h8_0001);
        chk("rr_nogntbusy", 64'(port_gnt_o), 64'h0);
        next_cycle();
        lkp_data_i = 64'h1111_2222_3333_4444;
        settle();
        chk("rr_rv0", 64'(port_rvalid_o), 64'h1);
        chk("rr_rd0", 64'(port_rdata_o), 64'h1111_2222_3333_4444);
        next_cycle(); settle();
        chk("rr_gnt1", 64'(port_gnt_o), 64'h2);
        next_cycle(); settle();
        chk("rr_idx1", 64'(lkp_idx_o), 64'hCDE);
        chk("rr_tag1", 64'(lkp_tag_o), 64'h123_4567_89AB);
        next_cycle();
        lkp_data_i = 64'h5555_6666_7777_8888;
        settle();
        chk("rr_rv1", 64'(port_rvalid_o), 64'h2);
        chk("rr_rd1", 64'(port_rdata_o), 64'h5555_6666_7777_8888);
        next_cycle(); settle();
        chk("rr_gnt0b", 64'(port_gnt_o), 64'h1);
        next_cycle(); settle();
        next_cycle();
        lkp_data_i = 64'h9999_AAAA_BBBB_CCCC;
        settle();
        chk("rr_rv0b", 64'(port_rvalid_o), 64'h1);
        chk("rr_rd0b", 64'(port_rdata_o), 64'h9999_AAAA_BBBB_CCCC);

        // Cacheable miss on port 0 (pointer currently 1, search wraps to 0).
        next_cycle();
        port_req_i = 2'b01; lkp_hit_i = 1'b0;
        settle();
        chk("miss_gnt", 64'(port_gnt_o), 64'h1);
        next_cycle();
        port_req_i = 2'b00;
        settle();
        chk("miss_lkp", 64'(lkp_req_o), 64'h1);
        next_cycle(); settle();
        chk("miss_cmp_rv", 64'(port_rvalid_o), 64'h0);
        chk("miss_cmp_mreq", 64'(miss_req_o), 64'h0);
        next_cycle(); settle();
        chk("miss_req", 64'(miss_req_o), 64'h1);
        chk("miss_addr", 64'(miss_addr_o), 64'h8000_1040);
        chk("miss_nc", 64'(miss_nc_o), 64'h0);
        next_cycle();
        miss_ack_i = 1'b1;
        settle();
        chk("miss_req_hold", 64'(miss_req_o), 64'h1);
        chk("miss_addr_hold", 64'(miss_addr_o), 64'h8000_1040);
        next_cycle();
        miss_ack_i = 1'b0;
        settle();
        chk("miss_wait_req", 64'(miss_req_o), 64'h0);
        chk("miss_wait_rv", 64'(port_rvalid_o), 64'h0);
        next_cycle();
        miss_rvalid_i = 1'b1; miss_rdata_i = 64'hDEAD_BEEF_CAFE_F00D;
        settle();
        chk("miss_rv", 64'(port_rvalid_o), 64'h1);
        chk("miss_rd", 64'(port_rdata_o), 64'hDEAD_BEEF_CAFE_F00D);
        next_cycle();
        miss_rvalid_i = 1'b0;
        settle();
        chk("miss_idle", 64'(idle_o), 64'h1);

        // Cache disabled, port 1: bypasses lookup, non-cacheable miss.
        cache_en_i = 1'b0; port_req_i = 2'b10;
        settle();
        chk("nc_gnt", 64'(port_gnt_o), 64'h2);
        next_cycle();
        port_req_i = 2'b00; cache_en_i = 1'b1; miss_ack_i = 1'b1;
        settle();
        chk("nc_nolkp", 64'(lkp_req_o), 64'h0);
        chk("nc_req", 64'(miss_req_o), 64'h1);
        chk("nc_nc", 64'(miss_nc_o), 64'h1);
        chk("nc_addr", 64'(miss_addr_o), 64'(ADDR1));
        next_cycle();
        miss_ack_i = 1'b0; miss_rvalid_i = 1'b1; miss_rdata_i = 64'h0123_4567_89AB_CDEF;
        settle();
        chk("nc_rv", 64'(port_rvalid_o), 64'h2);
        chk("nc_rd", 64'(port_rdata_o), 64'h0123_4567_89AB_CDEF);

        // Kill of port 0 while waiting for refill.
        next_cycle();
        miss_rvalid_i = 1'b0; port_req_i = 2'b01;
        settle();
        chk("kill_gnt", 64'(port_gnt_o), 64'h1);
        next_cycle();
        port_req_i = 2'b00;
        settle();
        next_cycle(); settle();
        next_cycle();
        miss_ack_i = 1'b1;
        settle();
        chk("kill_mreq", 64'(miss_req_o), 64'h1);
        next_cycle();
        miss_ack_i = 1'b0; port_kill_i = 2'b01;
        settle();
        next_cycle();
        port_kill_i = 2'b00; miss_rvalid_i = 1'b1; miss_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        port_req_i = 2'b10;
        settle();
        chk("kill_rv", 64'(port_rvalid_o), 64'h0);
        chk("kill_rd", 64'(port_rdata_o), 64'h0);
        chk("kill_busy_gnt", 64'(port_gnt_o), 64'h0);
        next_cycle();
        miss_rvalid_i = 1'b0; lkp_hit_i = 1'b1;
        settle();
        chk("kill_next_gnt", 64'(port_gnt_o), 64'h2);
        next_cycle();
        port_req_i = 2'b00;
        settle();
        next_cycle();
        lkp_data_i = 64'h0F0F_0F0F_0F0F_0F0F;
        settle();
        chk("kill_after_rv", 64'(port_rvalid_o), 64'h2);

        // Flush raised during lookup with port 1 requesting.
        next_cycle();
        port_req_i = 2'b10;
        settle();
        chk("fl_gnt", 64'(port_gnt_o), 64'h2);
        next_cycle();
        flush_i = 1'b1; lkp_gnt_i = 1'b0;
        settle();
        chk("fl_lkp", 64'(lkp_req_o), 64'h1);
        next_cycle();
        lkp_gnt_i = 1'b1;
        settle();
        chk("fl_lkp_hold", 64'(lkp_req_o), 64'h1);
        chk("fl_tag_hold", 64'(lkp_tag_o), 64'h123_4567_89AB);
        next_cycle();
        lkp_data_i = 64'hFEED_FACE_0000_0001;
        settle();
        chk("fl_rv", 64'(port_rvalid_o), 64'h2);
        chk("fl_rd", 64'(port_rdata_o), 64'hFEED_FACE_0000_0001);
        for (int k = 0; k < 2; k++) begin
            next_cycle(); settle();
            chk("fl_block_gnt", 64'(port_gnt_o), 64'h0);
            chk("fl_block_idle", 64'(idle_o), 64'h1);
        end
        next_cycle();
        flush_i = 1'b0;
        settle();
        chk("fl_release_gnt", 64'(port_gnt_o), 64'h2);
        chk("fl_release_idle", 64'(idle_o), 64'h0);
        next_cycle();
        port_req_i = 2'b00;
        settle();
        next_cycle(); settle();
        chk("fl_rv2", 64'(port_rvalid_o), 64'h2);

        // Reset in MISS_REQ after the pointer has moved to 1.
        next_cycle();
        cache_en_i = 1'b0; port_req_i = 2'b01;
        settle();
        chk("rst_gnt", 64'(port_gnt_o), 64'h1);
        next_cycle();
        port_req_i = 2'b00; cache_en_i = 1'b1;
        settle();
        chk("rst_mreq", 64'(miss_req_o), 64'h1);
        rst_i = 1'b1;
        settle();
        chk_quiet("rst_mid");
        next_cycle();
        rst_i = 1'b0; port_req_i = 2'b11;
        settle();
        chk("rst_rr_gnt", 64'(port_gnt_o), 64'h1);

        next_cycle();
        port_req_i = 2'b00;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
